hack_run_controller: RTL and testbench
======================================

Name: hack_run_controller

Overview:
- Parametrised run/debug controller for the Hack computer.
- Supersedes the fixed debug clock divider. It does not produce a derived clock; it produces a single-cycle clock enable (o_CPU_CE) that qualifies CPU, ROM and Memory updates on i_CLK.
- Adds halt, full-speed run, divided run, single-step, PC breakpoints and an executed-instruction counter.

Parameters:
PC_WIDTH, 16, width of program counter and breakpoint addresses
DIV_WIDTH, 24, width of divided-run reload value
NUM_BP, 2, number of PC breakpoint comparators (1..8)
CNT_WIDTH, 32, width of executed-instruction counter

Ports:
i_CLK  in  1  system clock; all state updates on rising edge
i_RESET  in  1  synchronous, active-high reset
i_Mode  in  2  00 halt, 01 run full speed, 10 run divided, 11 treated as halt
i_Div  in  DIV_WIDTH  divided mode: one CE every i_Div+1 cycles
i_Step  in  1  single-step request, level; rising edge acts
i_Resume  in  1  leave BREAK, level; rising edge acts
i_PC  in  PC_WIDTH  current PC from CPU (registered in CPU)
i_BP_Addr  in  NUM_BP*PC_WIDTH  breakpoint n at bits [n*PC_WIDTH +: PC_WIDTH]
i_BP_EN  in  NUM_BP  per-breakpoint enable
o_CPU_CE  out  1  CPU/ROM/Memory clock enable; one instruction per high cycle
o_Halted  out  1  high in HALT or BREAK
o_BP_Hit  out  NUM_BP  sticky mask of breakpoints that caused the last BREAK
o_Cycle_Count  out  CNT_WIDTH  number of cycles with o_CPU_CE high, wraps

Behaviour:
- Reset: state=HALT, o_CPU_CE=0, o_Halted=1, o_BP_Hit=0, o_Cycle_Count=0, divider count=0, skip flag=0. Step/resume edge detectors are cleared to 0. A level held high through reset therefore acts as an edge in the first cycle after reset.
- Priority: reset > mode halt (00/11) > breakpoint > resume > step > CE generation.
- States:
  - HALT: o_CPU_CE=0. i_Mode 01/10 -> RUN, with divider count cleared. Otherwise, step edge -> STEP.
  - RUN: i_Mode 00/11 -> HALT; no CE in that cycle. Otherwise, if match && !skip -> BREAK; no CE in that cycle; o_BP_Hit <= match mask.
  - STEP: o_CPU_CE=1 for exactly this one cycle; breakpoints ignored; next state HALT.
  - BREAK: o_CPU_CE=0. Mode 00/11 -> HALT, o_BP_Hit held. Resume edge -> RUN, with skip<=1, o_BP_Hit<=0, divider cleared. Step edge (no resume) -> STEP.
- Match: bit n = i_BP_EN[n] && i_BP_Addr[n] == i_PC. This is combinational within the cycle, so a matching PC suppresses CE in the same cycle and the instruction at that PC is not executed.
- CE in RUN: o_CPU_CE is combinational from registered state plus i_Mode, i_PC and the divider.
  - Full speed: CE=1 every RUN cycle not blocked by halt or match.
  - Divided: CE=1 when divider count==i_Div, and the count then returns to 0. Otherwise the count increments.
  - i_Div=0 is identical to full speed.
  - i_Div is sampled live; lowering it below the current count forces the next CE at wrap-around of DIV_WIDTH. This is permitted and is not an error.
- Skip flag: cleared on the first CE after it was set. While set, breakpoints are ignored, so resume executes the breakpointed instruction.
- Mode switch 01<->10 in RUN: stay in RUN; divider cleared on the switch.
- o_Cycle_Count increments by 1 on every edge where o_CPU_CE=1; it wraps from all-ones to 0.
- Step and resume edges are ignored in RUN and STEP; edge detection continues in those states.
- Reset mid-STEP or mid-divide: returns to HALT the next edge; no further CE.

Test Plan:
- Reset, i_Mode=00, pulse i_Step 3 times -> exactly 3 single-cycle CE pulses, o_Cycle_Count=3, o_Halted=1 throughout except during STEP cycles.
- i_Mode=10, i_Div=4, i_PC incrementing on CE, run 50 cycles -> CE every 5th cycle, o_Cycle_Count=10; then i_Div=0 -> CE every cycle.
- i_BP_EN=01, i_BP_Addr[0]=16'd7, i_Mode=01 from PC 0 -> CE for PCs 0..6, no CE at PC 7, BREAK entered, o_BP_Hit=01, o_Cycle_Count=7.
- From that BREAK, assert i_Resume -> PC 7 executed (skip), run continues; PC wraps back to 7 -> breaks again.
- Both breakpoints at 16'd3, both enabled -> o_BP_Hit=11. In BREAK, i_Step and i_Resume rising in the same cycle -> resume wins, state RUN.
- i_Mode=01 running, assert i_RESET for 1 cycle -> next cycle o_CPU_CE=0, o_Halted=1, o_Cycle_Count=0, o_BP_Hit=0. Also preload the counter to all-ones in simulation, then issue one CE -> counter=0.

Source files
------------

// File: rtl/hack_run_controller.sv
// Run/debug controller for the Hack computer: produces a single-cycle CPU clock
// enable for halt, full-speed, divided, single-step and PC-breakpoint operation.
module hack_run_controller #(
  parameter int PC_WIDTH  = 16,
  parameter int DIV_WIDTH = 24,
  parameter int NUM_BP    = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic [1:0]                 i_Mode,
  input  logic [DIV_WIDTH-1:0]       i_Div,
  input  logic                       i_Step,
  input  logic                       i_Resume,
  input  logic [PC_WIDTH-1:0]        i_PC,
  input  logic [NUM_BP*PC_WIDTH-1:0] i_BP_Addr,
  input  logic [NUM_BP-1:0]          i_BP_EN,
  output logic                       o_CPU_CE,
  output logic                       o_Halted,
  output logic [NUM_BP-1:0]          o_BP_Hit,
  output logic [CNT_WIDTH-1:0]       o_Cycle_Count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 skip_q, skip_d;
  logic [NUM_BP-1:0]    bp_hit_q, bp_hit_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                 step_prev_q, resume_prev_q;
  logic                 div_mode_q, div_mode_d;

  logic                 mode_full, mode_div, mode_run, mode_switch;
  logic                 step_edge, resume_edge;
  logic [NUM_BP-1:0]    match;
  logic [DIV_WIDTH-1:0] eff_cnt;
  logic                 ce;

  assign mode_full   = (i_Mode == 2'b01);
  assign mode_div    = (i_Mode == 2'b10);
  assign mode_run    = mode_full || mode_div;
  // A 01<->10 change seen while running restarts the divider.
  assign mode_switch = (mode_full && div_mode_q) || (mode_div && !div_mode_q);
  assign step_edge   = i_Step && !step_prev_q;
  assign resume_edge = i_Resume && !resume_prev_q;

  always_comb begin
    match = '0;
    for (int n = 0; n < NUM_BP; n++) begin
      match[n] = i_BP_EN[n] && (i_BP_Addr[n*PC_WIDTH +: PC_WIDTH] == i_PC);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    skip_d     = skip_q;
    bp_hit_d   = bp_hit_q;
    div_mode_d = mode_div;
    eff_cnt    = mode_switch ? '0 : div_cnt_q;
    ce         = 1'b0;

    unique case (state_q)
      S_HALT: begin
        if (mode_run) begin
          state_d   = S_RUN;
          div_cnt_d = '0;
        end else if (step_edge) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (!mode_run) begin
          state_d = S_HALT;
        end else if ((|match) && !skip_q) begin
          state_d   = S_BREAK;
          bp_hit_d  = match;
          div_cnt_d = eff_cnt;
        end else if (mode_full || (eff_cnt == i_Div)) begin
          ce        = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = eff_cnt + DIV_WIDTH'(1);
        end
      end
      S_STEP: begin
        ce      = 1'b1;
        state_d = S_HALT;
      end
      S_BREAK: begin
        if (!mode_run) begin
          state_d = S_HALT;
        end else if (resume_edge) begin
          state_d   = S_RUN;
          skip_d    = 1'b1;
          bp_hit_d  = '0;
          div_cnt_d = '0;
        end else if (step_edge) begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_HALT;
    endcase

    if (ce) skip_d = 1'b0;
    cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(ce);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q       <= S_HALT;
      div_cnt_q     <= '0;
      skip_q        <= 1'b0;
      bp_hit_q      <= '0;
      cycle_cnt_q   <= '0;
      step_prev_q   <= 1'b0;
      resume_prev_q <= 1'b0;
      div_mode_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      skip_q        <= skip_d;
      bp_hit_q      <= bp_hit_d;
      cycle_cnt_q   <= cycle_cnt_d;
      step_prev_q   <= i_Step;
      resume_prev_q <= i_Resume;
      div_mode_q    <= div_mode_d;
    end
  end

  // Reset suppresses the enable immediately so no instruction retires during it.
  assign o_CPU_CE      = ce && !i_RESET;
  assign o_Halted      = (state_q == S_HALT) || (state_q == S_BREAK);
  assign o_BP_Hit      = bp_hit_q;
  assign o_Cycle_Count = cycle_cnt_q;

endmodule

// File: tb/tb_hack_run_controller.sv
// Directed bench for hack_run_controller: vector table for stepping plus hand
// sequences for divided run, breakpoints, resume/step priority, reset and wrap.
module tb_hack_run_controller;
  localparam int PW = 16;
  localparam int DW = 24;
  localparam int NB = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [1:0]     mode;
  logic [DW-1:0]  div;
  logic           step, resume;
  logic [PW-1:0]  pc, pc_max;
  logic [NB*PW-1:0] bp_addr;
  logic [NB-1:0]  bp_en;

  logic           ce, halted, ce_small, halted_small;
  logic [NB-1:0]  hit, hit_small;
  logic [CW-1:0]  cnt;
  logic [2:0]     cnt_small;

  logic           ce_s, halted_s;
  logic [NB-1:0]  hit_s;
  logic [CW-1:0]  cnt_s;
  logic [2:0]     cnt_small_s;

  int n_checks = 0;
  int n_fail   = 0;

  hack_run_controller #(.PC_WIDTH(PW), .DIV_WIDTH(DW), .NUM_BP(NB), .CNT_WIDTH(CW)) dut (
    .i_CLK(clk), .i_RESET(rst), .i_Mode(mode), .i_Div(div), .i_Step(step),
    .i_Resume(resume), .i_PC(pc), .i_BP_Addr(bp_addr), .i_BP_EN(bp_en),
    .o_CPU_CE(ce), .o_Halted(halted), .o_BP_Hit(hit), .o_Cycle_Count(cnt)
  );

  // Narrow counter instance so counter wrap-around is reachable quickly.
  hack_run_controller #(.PC_WIDTH(PW), .DIV_WIDTH(DW), .NUM_BP(NB), .CNT_WIDTH(3)) dut_small (
    .i_CLK(clk), .i_RESET(rst), .i_Mode(mode), .i_Div(div), .i_Step(step),
    .i_Resume(resume), .i_PC(pc), .i_BP_Addr(bp_addr), .i_BP_EN(bp_en),
    .o_CPU_CE(ce_small), .o_Halted(halted_small), .o_BP_Hit(hit_small),
    .o_Cycle_Count(cnt_small)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic       step;
    logic       resume;
    logic       exp_ce;
    logic       exp_halted;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: sample outputs at negedge, then advance the CPU model's PC.
  task automatic clk_cycle();
    @(negedge clk);
    ce_s        = ce;
    halted_s    = halted;
    hit_s       = hit;
    cnt_s       = cnt;
    cnt_small_s = cnt_small;
    @(posedge clk);
    #1;
    if (ce_s) pc = (pc == pc_max) ? '0 : pc + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    pc  = '0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; div = '0; step = 1'b0; resume = 1'b0;
    pc = '0; pc_max = '1; bp_addr = '0; bp_en = '0;

    // Step pulses in halt mode: {mode, step, resume, exp_ce, exp_halted}
    vecs[0]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1};

    clk_cycle();
    clk_cycle();
    rst = 1'b0;
    clk_cycle();
    check("reset_ce", ce_s, 1'b0);
    check("reset_halted", halted_s, 1'b1);
    check("reset_hit", hit_s, 2'b00);
    check("reset_cnt", cnt_s, 32'd0);

    for (int i = 0; i < 12; i++) begin
      mode = vecs[i].mode; step = vecs[i].step; resume = vecs[i].resume;
      clk_cycle();
      check($sformatf("vec%0d_ce", i), ce_s, vecs[i].exp_ce);
      check($sformatf("vec%0d_halted", i), halted_s, vecs[i].exp_halted);
    end
    check("step_cnt", cnt_s, 32'd3);
    check("step_cnt_small", cnt_small_s, 3'd3);

    // Divided run, i_Div=4: CE on every 5th RUN cycle, then full rate with i_Div=0
    do_reset();
    mode = 2'b10; div = 24'd4;
    clk_cycle();
    check("div_enter_ce", ce_s, 1'b0);
    for (int i = 0; i < 50; i++) begin
      clk_cycle();
      check($sformatf("div4_ce%0d", i), ce_s, (i % 5) == 4);
    end
    div = '0;
    for (int i = 0; i < 10; i++) begin
      clk_cycle();
      if (i == 0) check("div4_cnt", cnt_s, 32'd10);
      check($sformatf("div0_ce%0d", i), ce_s, 1'b1);
    end
    mode = 2'b00;
    clk_cycle();
    check("run_to_halt_ce", ce_s, 1'b0);
    clk_cycle();
    check("run_to_halt_halted", halted_s, 1'b1);

    // Breakpoint 0 at PC 7, full-speed run from PC 0, PC wraps after 9
    do_reset();
    pc_max = 16'd9; bp_addr = {16'd0, 16'd7}; bp_en = 2'b01; mode = 2'b01;
    clk_cycle();
    check("bp_enter_ce", ce_s, 1'b0);
    for (int i = 0; i < 7; i++) begin
      clk_cycle();
      check($sformatf("bp_run_ce%0d", i), ce_s, 1'b1);
    end
    clk_cycle();
    check("bp_match_ce", ce_s, 1'b0);
    clk_cycle();
    check("bp_break_halted", halted_s, 1'b1);
    check("bp_break_hit", hit_s, 2'b01);
    check("bp_break_cnt", cnt_s, 32'd7);

    // Resume executes PC 7, runs round the loop, breaks again at 7
    resume = 1'b1;
    clk_cycle();
    check("resume_edge_ce", ce_s, 1'b0);
    for (int i = 0; i < 10; i++) begin
      clk_cycle();
      if (i == 0) check("resume_hit_clr", hit_s, 2'b00);
      check($sformatf("resume_ce%0d", i), ce_s, 1'b1);
    end
    clk_cycle();
    check("rebreak_ce", ce_s, 1'b0);
    clk_cycle();
    check("rebreak_halted", halted_s, 1'b1);
    check("rebreak_hit", hit_s, 2'b01);
    check("rebreak_cnt", cnt_s, 32'd17);
    resume = 1'b0;

    // Halt from BREAK keeps the hit mask
    mode = 2'b00;
    clk_cycle();
    check("brk_halt_ce", ce_s, 1'b0);
    clk_cycle();
    check("brk_halt_hit", hit_s, 2'b01);

    // Both breakpoints at PC 3
    pc = 16'd1; bp_addr = {16'd3, 16'd3}; bp_en = 2'b11; mode = 2'b01;
    clk_cycle();
    clk_cycle();
    check("bp2_ce_pc1", ce_s, 1'b1);
    clk_cycle();
    check("bp2_ce_pc2", ce_s, 1'b1);
    clk_cycle();
    check("bp2_match_ce", ce_s, 1'b0);
    clk_cycle();
    check("bp2_halted", halted_s, 1'b1);
    check("bp2_hit", hit_s, 2'b11);

    // Step and resume rise together in BREAK: resume wins
    step = 1'b1; resume = 1'b1;
    clk_cycle();
    check("both_edge_ce", ce_s, 1'b0);
    clk_cycle();
    check("both_first_ce", ce_s, 1'b1);
    check("both_hit_clr", hit_s, 2'b00);
    clk_cycle();
    check("both_still_run_ce", ce_s, 1'b1);
    check("both_still_run_halted", halted_s, 1'b0);
    step = 1'b0; resume = 1'b0;
    for (int i = 0; i < 40 && !halted_s; i++) clk_cycle();
    check("bp2_rebreak_halted", halted_s, 1'b1);
    check("bp2_rebreak_hit", hit_s, 2'b11);

    // Reset while in BREAK clears the hit mask
    do_reset();
    clk_cycle();
    check("brk_reset_ce", ce_s, 1'b0);
    check("brk_reset_halted", halted_s, 1'b1);
    check("brk_reset_hit", hit_s, 2'b00);
    check("brk_reset_cnt", cnt_s, 32'd0);

    // Reset asserted for one cycle while running at full speed
    bp_en = '0;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      check($sformatf("prerst_ce%0d", i), ce_s, 1'b1);
    end
    rst = 1'b1;
    clk_cycle();
    check("rst_cycle_ce", ce_s, 1'b0);
    rst = 1'b0;
    clk_cycle();
    check("run_reset_ce", ce_s, 1'b0);
    check("run_reset_halted", halted_s, 1'b1);
    check("run_reset_cnt", cnt_s, 32'd0);
    check("run_reset_hit", hit_s, 2'b00);

    // Eight steps: the 3-bit counter wraps from 7 to 0
    mode = 2'b00;
    clk_cycle();
    check("wrap_halt_ce", ce_s, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step = 1'b1;
      clk_cycle();
      step = 1'b0;
      clk_cycle();
      clk_cycle();
    end
    clk_cycle();
    check("wrap_cnt", cnt_s, 32'd8);
    check("wrap_cnt_small", cnt_small_s, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
